instr_sequencer: RTL and testbench

- Main state machine of the simple processor. Generates the 6-bit state code consumed by control_unit, which turns it into the 20-bit control word.
- Steps the machine through the fetch, decode and execute phases, branching on the instruction register opcode and the ALU zero flag.
- Also handles halt/resume, flags illegal opcodes, and keeps a retired-instruction counter.

---
 rtl/proc_pkg.sv | 46 ++++
 rtl/instr_sequencer.sv | 111 +++++++++++
 tb/tb_instr_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared encodings for the processor: sequencer state codes and instruction opcodes.
// Latency: n/a (constants only).
// Backpressure: n/a.
package proc_pkg;

    // 6-bit state codes, also decoded by control_unit into the control word
    localparam logic [5:0] ST_IDLE   = 6'd0;
    localparam logic [5:0] ST_FETCH1 = 6'd1;
    localparam logic [5:0] ST_FETCH2 = 6'd2;
    localparam logic [5:0] ST_FETCH3 = 6'd3;
    localparam logic [5:0] ST_FETCH4 = 6'd4;
    localparam logic [5:0] ST_FETCH5 = 6'd5;
    localparam logic [5:0] ST_FETCH6 = 6'd6;
    localparam logic [5:0] ST_LDR11  = 6'd7;
    localparam logic [5:0] ST_LDR12  = 6'd8;
    localparam logic [5:0] ST_LDR13  = 6'd9;
    localparam logic [5:0] ST_LDR14  = 6'd10;
    localparam logic [5:0] ST_LDR21  = 6'd11;
    localparam logic [5:0] ST_LDR22  = 6'd12;
    localparam logic [5:0] ST_LDR23  = 6'd13;
    localparam logic [5:0] ST_LDR24  = 6'd14;
    localparam logic [5:0] ST_STAC1  = 6'd15;
    localparam logic [5:0] ST_STAC2  = 6'd16;
    localparam logic [5:0] ST_STAC3  = 6'd17;
    localparam logic [5:0] ST_STAC4  = 6'd18;
    localparam logic [5:0] ST_ADD    = 6'd19;
    localparam logic [5:0] ST_ADD2   = 6'd20;
    localparam logic [5:0] ST_MUL    = 6'd21;
    localparam logic [5:0] ST_JMP1   = 6'd22;
    localparam logic [5:0] ST_HALT   = 6'd23;

    // Instruction opcodes as held in the instruction register
    localparam int unsigned OP_LDR1 = 1;
    localparam int unsigned OP_LDR2 = 2;
    localparam int unsigned OP_STAC = 3;
    localparam int unsigned OP_ADD  = 4;
    localparam int unsigned OP_MUL  = 5;
    localparam int unsigned OP_JMP  = 6;
    localparam int unsigned OP_JMPZ = 7;
    localparam int unsigned OP_HALT = 8;

    // Legal opcodes form one contiguous range
    localparam int unsigned OP_LEGAL_MIN = OP_LDR1;
    localparam int unsigned OP_LEGAL_MAX = OP_HALT;

endpackage

// File: rtl/instr_sequencer.sv
// Processor main FSM: fetch/decode/execute sequencing, halt/resume, illegal-opcode flag, retired count.
// Latency: state is registered; next state appears one clock after the deciding inputs.
// Backpressure: none; start is only honoured in IDLE and HALT, opcode/z_flag only in FETCH6.
module instr_sequencer
    import proc_pkg::*;
#(
    parameter int OPCODE_W = 8,
    parameter int COUNT_W  = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                z_flag,
    output logic [5:0]          state,
    output logic                busy,
    output logic                halted,
    output logic                illegal_op,
    output logic [COUNT_W-1:0]  instr_count
);

    logic [5:0]         state_q, state_d;
    logic               illegal_op_q, illegal_op_d;
    logic [COUNT_W-1:0] instr_count_q, instr_count_d;
    logic               op_legal;

    // Opcode falls inside the contiguous legal range
    always_comb begin
        op_legal = (opcode >= OPCODE_W'(OP_LEGAL_MIN)) && (opcode <= OPCODE_W'(OP_LEGAL_MAX));
    end

    // Next-state, retired-count and illegal-pulse computation
    always_comb begin
        state_d       = ST_IDLE;
        instr_count_d = instr_count_q;
        illegal_op_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_FETCH1;
                    instr_count_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH1, ST_FETCH2, ST_FETCH3, ST_FETCH4, ST_FETCH5: begin
                state_d = state_q + 6'd1;
            end
            ST_FETCH6: begin
                // Illegal opcodes and JMPZ not-taken fall back to a fresh fetch
                state_d = ST_FETCH1;
                if (op_legal) begin
                    instr_count_d = instr_count_q + COUNT_W'(1);
                end else begin
                    illegal_op_d = 1'b1;
                end
                case (opcode)
                    OPCODE_W'(OP_LDR1): state_d = ST_LDR11;
                    OPCODE_W'(OP_LDR2): state_d = ST_LDR21;
                    OPCODE_W'(OP_STAC): state_d = ST_STAC1;
                    OPCODE_W'(OP_ADD):  state_d = ST_ADD;
                    OPCODE_W'(OP_MUL):  state_d = ST_MUL;
                    OPCODE_W'(OP_JMP):  state_d = ST_JMP1;
                    OPCODE_W'(OP_JMPZ): state_d = z_flag ? ST_JMP1 : ST_FETCH1;
                    OPCODE_W'(OP_HALT): state_d = ST_HALT;
                    default:            state_d = ST_FETCH1;
                endcase
            end
            ST_LDR11, ST_LDR12, ST_LDR13,
            ST_LDR21, ST_LDR22, ST_LDR23,
            ST_STAC1, ST_STAC2, ST_STAC3,
            ST_ADD: begin
                state_d = state_q + 6'd1;
            end
            ST_LDR14, ST_LDR24, ST_STAC4, ST_ADD2, ST_MUL, ST_JMP1: begin
                state_d = ST_FETCH1;
            end
            ST_HALT: begin
                // Resume keeps the retired count, unlike a start from IDLE
                state_d = start ? ST_FETCH1 : ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and pulse registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            illegal_op_q  <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            illegal_op_q  <= illegal_op_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Status flags decoded straight from the state register
    always_comb begin
        busy   = (state_q != ST_IDLE) && (state_q != ST_HALT);
        halted = (state_q == ST_HALT);
    end

    assign state       = state_q;
    assign illegal_op  = illegal_op_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a 4-bit retired counter so wrap is reachable.
module tb_instr_sequencer;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic [7:0] opcode;
    logic       z_flag;
    logic [5:0] state;
    logic       busy;
    logic       halted;
    logic       illegal_op;
    logic [3:0] instr_count;

    int         checks;
    int         errors;
    logic [3:0] exp_cnt;

    instr_sequencer #(
        .OPCODE_W (8),
        .COUNT_W  (4)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .opcode      (opcode),
        .z_flag      (z_flag),
        .state       (state),
        .busy        (busy),
        .halted      (halted),
        .illegal_op  (illegal_op),
        .instr_count (instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        opcode  = 8'd0;
        z_flag  = 1'b0;
        tick();
        tick();
        checks++;
        if (state !== 6'd0 || instr_count !== 4'd0 || illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL reset: state=%0d cnt=%0d ill=%0d, expected 0/0/0", state, instr_count, illegal_op);
        end
        checks++;
        if (busy !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%0d halted=%0d, expected 0/0", busy, halted);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (state !== 6'd0) begin
                errors++;
                $display("FAIL idle_hold step %0d: state=%0d, expected 0", i, state);
            end
        end
    endtask

    // Start from IDLE with ADD: 1..6,19,20,1
    task automatic test_add();
        logic [5:0] exp_s [$];
        exp_s = {6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd19, 6'd20, 6'd1};
        opcode = 8'd4;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        exp_cnt = 4'd0;
        checks++;
        if (state !== 6'd1 || busy !== 1'b1 || instr_count !== 4'd0) begin
            errors++;
            $display("FAIL add_start: state=%0d busy=%0d cnt=%0d, expected 1/1/0", state, busy, instr_count);
        end
        for (int i = 0; i < exp_s.size(); i++) begin
            tick();
            checks++;
            if (state !== exp_s[i] || busy !== 1'b1) begin
                errors++;
                $display("FAIL add_seq step %0d: state=%0d busy=%0d, expected %0d/1", i, state, busy, exp_s[i]);
            end
            if (i == 5) begin
                checks++;
                if (instr_count !== 4'd1) begin
                    errors++;
                    $display("FAIL add_count: cnt=%0d, expected 1", instr_count);
                end
            end
        end
        exp_cnt = 4'd1;
    endtask

    // Illegal opcode: straight back to FETCH1 with a one-cycle pulse, count held
    task automatic test_illegal();
        logic [5:0] exp_s [$];
        exp_s = {6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd1};
        opcode = 8'hFF;
        for (int i = 0; i < exp_s.size(); i++) begin
            tick();
            checks++;
            if (state !== exp_s[i] || illegal_op !== (i == 5)) begin
                errors++;
                $display("FAIL illegal_seq step %0d: state=%0d ill=%0d, expected %0d/%0d",
                         i, state, illegal_op, exp_s[i], (i == 5));
            end
        end
        checks++;
        if (instr_count !== exp_cnt) begin
            errors++;
            $display("FAIL illegal_count: cnt=%0d, expected %0d", instr_count, exp_cnt);
        end
    endtask

    // LDR1 with start held high to show it is ignored while busy; pulse must have dropped
    task automatic test_ldr();
        logic [5:0] exp_s [$];
        exp_s = {6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd1};
        opcode = 8'd1;
        start  = 1'b1;
        for (int i = 0; i < exp_s.size(); i++) begin
            tick();
            checks++;
            if (state !== exp_s[i] || illegal_op !== 1'b0) begin
                errors++;
                $display("FAIL ldr_seq step %0d: state=%0d ill=%0d, expected %0d/0", i, state, illegal_op, exp_s[i]);
            end
        end
        start = 1'b0;
        exp_cnt = exp_cnt + 4'd1;
        checks++;
        if (instr_count !== exp_cnt) begin
            errors++;
            $display("FAIL ldr_count: cnt=%0d, expected %0d", instr_count, exp_cnt);
        end
    endtask

    // JMPZ not-taken then taken; both retire
    task automatic test_jmpz();
        logic [5:0] exp_nt [$];
        logic [5:0] exp_t [$];
        exp_nt = {6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd1};
        exp_t  = {6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd22, 6'd1};
        opcode = 8'd7;
        z_flag = 1'b0;
        for (int i = 0; i < exp_nt.size(); i++) begin
            tick();
            checks++;
            if (state !== exp_nt[i]) begin
                errors++;
                $display("FAIL jmpz_nt step %0d: state=%0d, expected %0d", i, state, exp_nt[i]);
            end
        end
        exp_cnt = exp_cnt + 4'd1;
        checks++;
        if (instr_count !== exp_cnt) begin
            errors++;
            $display("FAIL jmpz_nt_count: cnt=%0d, expected %0d", instr_count, exp_cnt);
        end
        z_flag = 1'b1;
        for (int i = 0; i < exp_t.size(); i++) begin
            tick();
            checks++;
            if (state !== exp_t[i]) begin
                errors++;
                $display("FAIL jmpz_t step %0d: state=%0d, expected %0d", i, state, exp_t[i]);
            end
        end
        z_flag = 1'b0;
        exp_cnt = exp_cnt + 4'd1;
        checks++;
        if (instr_count !== exp_cnt) begin
            errors++;
            $display("FAIL jmpz_t_count: cnt=%0d, expected %0d", instr_count, exp_cnt);
        end
    endtask

    // Remaining execute chains: LDR2, STAC, MUL, JMP
    task automatic test_other_ops();
        logic [5:0] exp_s [$];
        logic [7:0] ops [4];
        ops = '{8'd2, 8'd3, 8'd5, 8'd6};
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: exp_s = {6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd11, 6'd12, 6'd13, 6'd14, 6'd1};
                1: exp_s = {6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd15, 6'd16, 6'd17, 6'd18, 6'd1};
                2: exp_s = {6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd21, 6'd1};
                default: exp_s = {6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd22, 6'd1};
            endcase
            opcode = ops[k];
            for (int i = 0; i < exp_s.size(); i++) begin
                tick();
                checks++;
                if (state !== exp_s[i]) begin
                    errors++;
                    $display("FAIL op%0d_seq step %0d: state=%0d, expected %0d", ops[k], i, state, exp_s[i]);
                end
            end
            exp_cnt = exp_cnt + 4'd1;
            checks++;
            if (instr_count !== exp_cnt) begin
                errors++;
                $display("FAIL op%0d_count: cnt=%0d, expected %0d", ops[k], instr_count, exp_cnt);
            end
        end
    endtask

    // HALT: parks for 20 cycles, resumes on start without clearing the count
    task automatic test_halt();
        logic [5:0] exp_s [$];
        exp_s = {6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd23};
        opcode = 8'd8;
        for (int i = 0; i < exp_s.size(); i++) begin
            tick();
            checks++;
            if (state !== exp_s[i]) begin
                errors++;
                $display("FAIL halt_seq step %0d: state=%0d, expected %0d", i, state, exp_s[i]);
            end
        end
        exp_cnt = exp_cnt + 4'd1;
        checks++;
        if (instr_count !== exp_cnt || halted !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL halt_entry: cnt=%0d halted=%0d busy=%0d, expected %0d/1/0",
                     instr_count, halted, busy, exp_cnt);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (state !== 6'd23 || halted !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL halt_hold cycle %0d: state=%0d halted=%0d busy=%0d, expected 23/1/0",
                         i, state, halted, busy);
            end
        end
        opcode = 8'd4;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        checks++;
        if (state !== 6'd1 || instr_count !== exp_cnt || halted !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL halt_resume: state=%0d cnt=%0d halted=%0d busy=%0d, expected 1/%0d/0/1",
                     state, instr_count, halted, busy, exp_cnt);
        end
    endtask

    // Restart from IDLE, 16 ADDs wrap the 4-bit count to 0, then reset mid-LDR
    task automatic test_wrap_and_abort();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        opcode  = 8'd4;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        exp_cnt = 4'd0;
        checks++;
        if (state !== 6'd1 || instr_count !== 4'd0) begin
            errors++;
            $display("FAIL wrap_start: state=%0d cnt=%0d, expected 1/0", state, instr_count);
        end
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < 8; i++) tick();
            exp_cnt = exp_cnt + 4'd1;
            checks++;
            if (state !== 6'd1 || instr_count !== exp_cnt) begin
                errors++;
                $display("FAIL wrap add %0d: state=%0d cnt=%0d, expected 1/%0d", n, state, instr_count, exp_cnt);
            end
        end
        opcode = 8'd1;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (state !== 6'd8 || instr_count !== 4'd1) begin
            errors++;
            $display("FAIL abort_pre: state=%0d cnt=%0d, expected 8/1", state, instr_count);
        end
        reset_n = 1'b0;
        tick();
        checks++;
        if (state !== 6'd0 || instr_count !== 4'd0 || illegal_op !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: state=%0d cnt=%0d ill=%0d busy=%0d, expected 0/0/0/0",
                     state, instr_count, illegal_op, busy);
        end
        reset_n = 1'b1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = 4'd0;
        test_reset();
        test_add();
        test_illegal();
        test_ldr();
        test_jmpz();
        test_other_ops();
        test_halt();
        test_wrap_and_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
